// File: rtl/oflow_mem_buffer_ctrl.sv
// MEM history buffer controller: writes one frame of bboxes per ring slot and
// sweeps committed slots newest-to-oldest, issuing bbox address pairs.
module oflow_mem_buffer_ctrl #(
  parameter int MAX_HISTORY = 5,
  parameter int MAX_BBOX    = 32,
  parameter int FRAME_NUM_W = 8,
  parameter int HIST_W      = $clog2(MAX_HISTORY+1),
  parameter int BBOX_W      = $clog2(MAX_BBOX+1),
  parameter int ADDR_W      = $clog2(MAX_HISTORY*MAX_BBOX)
) (
  input  logic                   clk,
  input  logic                   reset_N,
  input  logic [FRAME_NUM_W-1:0] frame_num,
  input  logic [HIST_W-1:0]      num_of_history_frames,
  input  logic                   start_write,
  input  logic                   wr_valid,
  input  logic                   wr_last,
  output logic                   wr_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic                   done_write,
  output logic                   err_overflow,
  input  logic                   start_read,
  input  logic                   line_ack,
  output logic                   rd_valid,
  output logic [ADDR_W-1:0]      rd_addr0,
  output logic [ADDR_W-1:0]      rd_addr1,
  output logic                   rd_addr1_valid,
  output logic [FRAME_NUM_W-1:0] rd_frame,
  output logic [HIST_W-1:0]      rd_hist_idx,
  output logic                   done_read,
  output logic                   busy_write,
  output logic                   busy_read
);

  localparam int SLOT_W = (MAX_HISTORY > 1) ? $clog2(MAX_HISTORY) : 1;
  localparam logic [SLOT_W-1:0] SLOT_ONE = 1;
  localparam logic [HIST_W-1:0] HIST_ONE = 1;
  localparam logic [HIST_W:0]   K_ONE    = 1;
  localparam logic [BBOX_W-1:0] BBOX_ONE = 1;

  localparam logic [1:0] W_IDLE = 2'd0, W_ACTIVE = 2'd1, W_COMMIT = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_SCAN = 2'd1, R_ISSUE = 2'd2, R_DONE = 2'd3;

  logic [1:0]             w_state_q, w_state_d;
  logic [BBOX_W-1:0]      cnt_q, cnt_d;
  logic [SLOT_W-1:0]      wr_slot_q;
  logic [HIST_W-1:0]      committed_q;
  logic [BBOX_W-1:0]      end_ptr_q [MAX_HISTORY];
  logic [MAX_HISTORY-1:0] valid_q;
  logic                   err_q;
  logic                   beat_end;

  assign wr_ready     = (w_state_q == W_ACTIVE);
  assign mem_we       = wr_ready & wr_valid;
  assign mem_waddr    = ADDR_W'(int'(wr_slot_q) * MAX_BBOX + int'(cnt_q));
  assign done_write   = (w_state_q == W_COMMIT);
  assign busy_write   = (w_state_q != W_IDLE);
  assign err_overflow = err_q;
  assign beat_end     = mem_we & (wr_last | (cnt_q == BBOX_W'(MAX_BBOX-1)));

  always_comb begin
    w_state_d = w_state_q;
    cnt_d     = cnt_q;
    case (w_state_q)
      W_IDLE: if (start_write) begin
        w_state_d = W_ACTIVE;
        cnt_d     = '0;
      end
      W_ACTIVE: begin
        if (mem_we) cnt_d = cnt_q + BBOX_ONE;
        if (beat_end) w_state_d = W_COMMIT;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      w_state_q   <= W_IDLE;
      cnt_q       <= '0;
      wr_slot_q   <= '0;
      committed_q <= '0;
      valid_q     <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < MAX_HISTORY; i++) end_ptr_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      cnt_q     <= cnt_d;
      // slot becomes invisible to the reader as soon as it is reopened
      if (w_state_q == W_IDLE && start_write) valid_q[wr_slot_q] <= 1'b0;
      if (mem_we && cnt_q == BBOX_W'(MAX_BBOX-1) && !wr_last) err_q <= 1'b1;
      if (w_state_q == W_COMMIT) begin
        end_ptr_q[wr_slot_q] <= cnt_q;
        valid_q[wr_slot_q]   <= 1'b1;
        wr_slot_q <= (wr_slot_q == SLOT_W'(MAX_HISTORY-1)) ? '0 : wr_slot_q + SLOT_ONE;
        if (committed_q != HIST_W'(MAX_HISTORY)) committed_q <= committed_q + HIST_ONE;
      end
    end
  end

  logic [1:0]             r_state_q, r_state_d;
  logic [HIST_W:0]        k_q, k_d;
  logic [HIST_W-1:0]      h_q, h_d, h_sel;
  logic [SLOT_W-1:0]      base_q, base_d, s_q, s_d, scan_slot;
  logic [BBOX_W-1:0]      off_q, off_d, end_cur;
  logic [FRAME_NUM_W-1:0] frame_q, frame_d;
  logic                   gap_q, gap_d;
  logic                   scan_hit, ack;
  logic [BBOX_W:0]        off_next;
  logic [ADDR_W-1:0]      addr0;
  int                     scan_i;

  always_comb begin
    h_sel = num_of_history_frames;
    if (h_sel > HIST_W'(MAX_HISTORY)) h_sel = HIST_W'(MAX_HISTORY);
    if (h_sel > committed_q) h_sel = committed_q;
    scan_i = int'(base_q) - int'(k_q);
    if (scan_i < 0) scan_i = scan_i + MAX_HISTORY;
    scan_slot = SLOT_W'(scan_i);
  end

  assign scan_hit = valid_q[scan_slot] && (end_ptr_q[scan_slot] != '0);
  assign end_cur  = end_ptr_q[s_q];
  assign off_next = {1'b0, off_q} + (BBOX_W+1)'(2);
  // one-cycle bubble after each ack so the metric sees a clean valid edge
  assign rd_valid = (r_state_q == R_ISSUE) && !gap_q;
  assign ack      = rd_valid & line_ack;
  assign addr0    = ADDR_W'(int'(s_q) * MAX_BBOX + int'(off_q));

  assign rd_addr0       = rd_valid ? addr0 : '0;
  assign rd_addr1       = rd_valid ? addr0 + ADDR_W'(1) : '0;
  assign rd_addr1_valid = rd_valid && (({1'b0, off_q} + (BBOX_W+1)'(1)) < {1'b0, end_cur});
  assign rd_frame       = rd_valid ? frame_q - FRAME_NUM_W'(k_q) : '0;
  assign rd_hist_idx    = rd_valid ? k_q[HIST_W-1:0] : '0;
  assign done_read      = (r_state_q == R_DONE);
  assign busy_read      = (r_state_q != R_IDLE);

  always_comb begin
    r_state_d = r_state_q;
    k_d       = k_q;
    h_d       = h_q;
    base_d    = base_q;
    s_d       = s_q;
    off_d     = off_q;
    frame_d   = frame_q;
    gap_d     = 1'b0;
    case (r_state_q)
      R_IDLE: if (start_read) begin
        r_state_d = R_SCAN;
        k_d       = K_ONE;
        h_d       = h_sel;
        base_d    = wr_slot_q;
        frame_d   = frame_num;
      end
      R_SCAN: begin
        if (k_q > {1'b0, h_q}) r_state_d = R_DONE;
        else if (scan_hit) begin
          s_d       = scan_slot;
          off_d     = '0;
          r_state_d = R_ISSUE;
        end else k_d = k_q + K_ONE;
      end
      R_ISSUE: if (ack) begin
        if (off_next >= {1'b0, end_cur}) begin
          k_d       = k_q + K_ONE;
          r_state_d = R_SCAN;
        end else begin
          off_d = off_next[BBOX_W-1:0];
          gap_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      r_state_q <= R_IDLE;
      k_q       <= '0;
      h_q       <= '0;
      base_q    <= '0;
      s_q       <= '0;
      off_q     <= '0;
      frame_q   <= '0;
      gap_q     <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      k_q       <= k_d;
      h_q       <= h_d;
      base_q    <= base_d;
      s_q       <= s_d;
      off_q     <= off_d;
      frame_q   <= frame_d;
      gap_q     <= gap_d;
    end
  end

endmodule

// File: tb/tb_oflow_mem_buffer_ctrl.sv
// Directed bench for oflow_mem_buffer_ctrl with a small slot-ring reference model.
module tb_oflow_mem_buffer_ctrl;
  localparam int MAXH = 5;
  localparam int MAXB = 32;

  logic       clk = 1'b0;
  logic       reset_N = 1'b1;
  logic [7:0] frame_num = '0;
  logic [2:0] num_of_history_frames = '0;
  logic       start_write = 1'b0, wr_valid = 1'b0, wr_last = 1'b0;
  logic       start_read = 1'b0, line_ack = 1'b0;
  logic       wr_ready, mem_we, done_write, err_overflow;
  logic [7:0] mem_waddr, rd_addr0, rd_addr1, rd_frame;
  logic       rd_valid, rd_addr1_valid, done_read, busy_write, busy_read;
  logic [2:0] rd_hist_idx;

  int err_cnt = 0;
  int chk_cnt = 0;
  int m_end [MAXH];
  bit m_valid [MAXH];
  int m_slot = 0;
  int m_comm = 0;

  oflow_mem_buffer_ctrl dut (
    .clk(clk), .reset_N(reset_N), .frame_num(frame_num),
    .num_of_history_frames(num_of_history_frames),
    .start_write(start_write), .wr_valid(wr_valid), .wr_last(wr_last),
    .wr_ready(wr_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .done_write(done_write), .err_overflow(err_overflow),
    .start_read(start_read), .line_ack(line_ack), .rd_valid(rd_valid),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr1_valid(rd_addr1_valid),
    .rd_frame(rd_frame), .rd_hist_idx(rd_hist_idx), .done_read(done_read),
    .busy_write(busy_write), .busy_read(busy_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXH; i++) begin
      m_end[i] = 0;
      m_valid[i] = 0;
    end
    m_slot = 0;
    m_comm = 0;
  endtask

  task automatic do_write(input int n, input bit use_last);
    int  slot = m_slot;
    int  acc = 0;
    bit  ended = 0;
    bit  done_seen = 0;
    @(negedge clk); start_write = 1'b1;
    @(negedge clk); start_write = 1'b0;
    m_valid[slot] = 0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_last  = use_last && (i == n-1);
      #1;
      if (!ended) begin
        chk("wr_ready", wr_ready, 1);
        chk("mem_we", mem_we, 1);
        chk("mem_waddr", mem_waddr, slot*MAXB + i);
        acc++;
        if (wr_last || i == MAXB-1) ended = 1;
      end else begin
        chk("wr_ready_commit", wr_ready, 0);
        chk("mem_we_commit", mem_we, 0);
        if (i == acc) begin
          chk("done_write", done_write, 1);
          done_seen = 1;
        end
      end
      @(negedge clk);
    end
    if (!done_seen) chk("done_write", done_write, 1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    m_end[slot] = acc;
    m_valid[slot] = 1;
    m_slot = (m_slot + 1) % MAXH;
    if (m_comm < MAXH) m_comm++;
    @(negedge clk);
    chk("done_write_pulse", done_write, 0);
    chk("busy_write_idle", busy_write, 0);
  endtask

  task automatic do_read(input int num);
    int h, base, s, n;
    logic [7:0] a0;
    @(negedge clk); num_of_history_frames = 3'(num); start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    h = num;
    if (h > MAXH) h = MAXH;
    if (h > m_comm) h = m_comm;
    base = m_slot;
    for (int k = 1; k <= h; k++) begin
      s = (base - k + MAXH) % MAXH;
      if (m_valid[s] && m_end[s] > 0) begin
        for (int off = 0; off < m_end[s]; off += 2) begin
          n = 0;
          while (!rd_valid && n < 10) begin
            @(negedge clk);
            n++;
          end
          if (k == 1 && off == 0) chk("rd_latency", n, 1);
          chk("rd_valid", rd_valid, 1);
          chk("rd_addr0", rd_addr0, s*MAXB + off);
          chk("rd_addr1", rd_addr1, s*MAXB + off + 1);
          chk("rd_addr1_valid", rd_addr1_valid, (off + 1 < m_end[s]) ? 1 : 0);
          chk("rd_hist_idx", rd_hist_idx, k);
          chk("rd_frame", rd_frame, (frame_num - k) & 8'hFF);
          if (k == 1 && off == 0) begin
            a0 = rd_addr0;
            @(negedge clk);
            chk("rd_hold_valid", rd_valid, 1);
            chk("rd_hold_addr", rd_addr0, s*MAXB);
          end
          line_ack = 1'b1;
          @(negedge clk);
          line_ack = 1'b0;
          chk("rd_gap", rd_valid, 0);
        end
      end
    end
    n = 0;
    while (!done_read && !rd_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("done_read", done_read, 1);
    @(negedge clk);
    chk("busy_read_idle", busy_read, 0);
  endtask

  task automatic empty_read();
    @(negedge clk); num_of_history_frames = 3'd5; start_read = 1'b1;
    @(negedge clk); start_read = 1'b0;
    chk("empty_done_early", done_read, 0);
    chk("empty_busy", busy_read, 1);
    @(negedge clk);
    chk("empty_done", done_read, 1);
    chk("empty_no_valid", rd_valid, 0);
    @(negedge clk);
    chk("empty_done_pulse", done_read, 0);
    chk("empty_idle", busy_read, 0);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_done_write", done_write, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done_read", done_read, 0);
    chk("rst_busy", {busy_write, busy_read}, 0);
    repeat (2) @(negedge clk);
    reset_N = 1'b0;

    empty_read();

    frame_num = 8'd3;
    do_write(3, 1'b1);
    for (int f = 0; f < 5; f++) do_write(4, 1'b1);
    chk("overwrite_slot", m_slot, 1);
    do_read(5);

    frame_num = 8'd100;
    do_write(5, 1'b1);
    do_read(1);

    do_write(33, 1'b0);
    chk("err_overflow", err_overflow, 1);
    do_read(1);

    // reset in the middle of a sweep and a write
    @(negedge clk);
    num_of_history_frames = 3'd5; start_read = 1'b1; start_write = 1'b1;
    @(negedge clk);
    start_read = 1'b0; start_write = 1'b0; wr_valid = 1'b1;
    @(negedge clk);
    chk("mid_rd_valid", rd_valid, 1);
    chk("mid_busy_write", busy_write, 1);
    reset_N = 1'b1;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_busy", {busy_write, busy_read}, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_err", err_overflow, 0);
    chk("mid_rst_addr", rd_addr0, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    reset_N = 1'b0;
    model_reset();
    empty_read();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/oflow_mem_buffer_ctrl.md
Name: oflow_mem_buffer_ctrl

Overview:
Parametrised controller for the MEM history buffer. It holds up to MAX_HISTORY frames of bounding boxes in a slot ring.
- Write side: streams one frame's bboxes into the next ring slot with a valid/ready handshake, then commits a registered end pointer and valid bit for that slot.
- Read side: walks committed history frames from newest to oldest and issues bbox address pairs to the similarity metric, one line per acknowledge.
- Sits between the core and the buffer RAM, replacing the fixed 5-frame read/write FSM pair.

Parameters:
MAX_HISTORY, 5, number of ring slots (1..16)
MAX_BBOX, 32, bbox entries per slot (even, >=2)
FRAME_NUM_W, 8, frame serial number width (wraps)
HIST_W, $clog2(MAX_HISTORY+1), width of history count/index
BBOX_W, $clog2(MAX_BBOX+1), width of bbox count/offset
ADDR_W, $clog2(MAX_HISTORY*MAX_BBOX), RAM address width

Ports:
clk  in  1  clock, rising edge
reset_N  in  1  asynchronous, active-high reset (1 = reset asserted)
frame_num  in  FRAME_NUM_W  serial number of current frame
num_of_history_frames  in  HIST_W  history depth to read; sampled at start_read
start_write  in  1  pulse: begin storing a frame
wr_valid  in  1  bbox beat valid
wr_last  in  1  last bbox of frame, qualifies wr_valid
wr_ready  out  1  controller accepts beat
mem_we  out  1  RAM write enable
mem_waddr  out  ADDR_W  RAM write address
done_write  out  1  one-cycle pulse: frame committed
err_overflow  out  1  sticky: frame exceeded MAX_BBOX; cleared only by reset
start_read  in  1  pulse: begin history sweep
line_ack  in  1  similarity metric finished current line
rd_valid  out  1  rd_addr0/rd_addr1 valid; held until line_ack
rd_addr0  out  ADDR_W  first bbox address of line
rd_addr1  out  ADDR_W  second bbox address of line
rd_addr1_valid  out  1  rd_addr1 refers to a real bbox (odd count tail)
rd_frame  out  FRAME_NUM_W  frame number of slot being read (frame_num-k mod 2^FRAME_NUM_W)
rd_hist_idx  out  HIST_W  k, 1 = newest history frame
done_read  out  1  one-cycle pulse: sweep complete
busy_write  out  1  write FSM not idle
busy_read  out  1  read FSM not idle

Behaviour:
- Reset: all outputs 0; wr_slot=0; frames_committed=0; every end_ptr and valid bit cleared. Reset mid-operation aborts both FSMs immediately with no commit.
- State: registered end_ptr[MAX_HISTORY] (BBOX_W), valid[MAX_HISTORY], wr_slot (mod MAX_HISTORY), frames_committed (saturates at MAX_HISTORY). Slot selection is independent of frame_num, so frame_num wrap 255->0 is harmless.
- Write FSM W_IDLE/W_ACTIVE/W_COMMIT:
  - W_IDLE->W_ACTIVE on start_write. cnt=0. valid[wr_slot] is cleared in the same edge.
  - W_ACTIVE: wr_ready=1. Each wr_valid beat: mem_we=1 combinationally, mem_waddr=wr_slot*MAX_BBOX+cnt, cnt++.
  - Beat with wr_last, or beat at cnt==MAX_BBOX-1, goes to W_COMMIT. In the second case, if wr_last=0 then err_overflow<=1.
  - W_COMMIT (1 cycle): wr_ready=0; end_ptr[wr_slot]<=cnt; valid[wr_slot]<=1; wr_slot advances mod MAX_HISTORY; frames_committed++; done_write=1; next W_IDLE.
  - start_write while busy_write is ignored.
- Read FSM R_IDLE/R_SCAN/R_ISSUE/R_DONE:
  - On start_read, latch H=min(num_of_history_frames,MAX_HISTORY,frames_committed); k=1.
  - H==0: go to R_DONE, so done_read pulses 2 cycles after start_read.
  - R_SCAN (1 cycle per k): slot s=(wr_slot-k) mod MAX_HISTORY.
    - Skip s if valid[s]==0 or end_ptr[s]==0. valid[s] is 0 while s is being written.
    - Otherwise set off=0 and go to R_ISSUE.
    - Skipping increments k. When k>H, go to R_DONE.
  - R_ISSUE: rd_valid=1.
    - rd_addr0=s*MAX_BBOX+off; rd_addr1=rd_addr0+1; rd_addr1_valid=(off+1<end_ptr[s]).
    - rd_frame=frame_num_latched-k; rd_hist_idx=k.
    - Outputs are stable until line_ack. On line_ack, off+=2. If off>=end_ptr[s], k++ and go to R_SCAN; else stay.
    - line_ack outside R_ISSUE is ignored.
  - R_DONE: done_read=1 for one cycle, then R_IDLE. start_read while busy_read is ignored.
- Latency: start_read -> first rd_valid = 2 cycles; line_ack -> next rd_valid on the same slot = 1 cycle (rd_valid drops for that cycle).
- Simultaneous start_write and start_read: both accepted. The read sweep sees only slots committed before its R_SCAN of that slot. A commit during a sweep shifts wr_slot; the sweep uses wr_slot latched at start_read.

Test Plan:
- Reset, then write 3 bboxes with wr_last on beat 3 into slot 0 -> mem_waddr 0,1,2; done_write 1 cycle after last beat; end_ptr[0]=3.
- MAX_HISTORY=5: commit 6 frames of 4 bboxes -> 6th overwrites slot 0. start_read with num_of_history_frames=5 -> rd_hist_idx 1..5 from slots 0,4,3,2,1; 2 lines each; done_read after 10 acks.
- Frame of 5 bboxes, read it -> lines (0,1),(2,3),(4,x); rd_addr1_valid=0 on third line.
- Write 33 beats with MAX_BBOX=32 and no wr_last -> commit after beat 32; err_overflow=1; wr_ready=0 on beat 33.
- start_read with frames_committed=0 -> no rd_valid; done_read 2 cycles later.
- Assert reset_N=1 mid-sweep and mid-write -> all outputs 0 next edge; subsequent start_read gives immediate done_read.
